// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: fetch-stage, decode, redirect and status signals of the fetch sequencer
interface fetch_sequencer_if;
  logic        start_i;
  logic [31:0] fetch_pc_i;
  logic [31:0] fetch_instr_i;
  logic [31:0] pc_next_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        halted_o;
  logic        fault_o;
  logic [31:0] fetch_count_o;
  logic [31:0] stall_count_o;
  modport master (
    output start_i, fetch_pc_i, fetch_instr_i, out_ready_i, redirect_valid_i, redirect_pc_i,
    input  pc_next_o, out_valid_o, out_instr_o, out_pc_o, halted_o, fault_o, fetch_count_o, stall_count_o
  );
  modport slave (
    input  start_i, fetch_pc_i, fetch_instr_i, out_ready_i, redirect_valid_i, redirect_pc_i,
    output pc_next_o, out_valid_o, out_instr_o, out_pc_o, halted_o, fault_o, fetch_count_o, stall_count_o
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter owner for the fetch stage with redirect, halt, fault and perf counters
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_WORDS   = 256,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input logic clk,
  input logic rst,
  fetch_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED, FAULT} state_t;
  state_t      state_q, state_d;
  logic        halted_q, fault_q;
  logic [31:0] fetch_count_q, stall_count_q;
  logic        bad, run, out_valid, accept, stall;
  logic [31:0] pc_next;
  assign bad       = |bus.fetch_pc_i[1:0] || ({2'b00, bus.fetch_pc_i[31:2]} >= 32'(MEM_WORDS));
  assign run       = state_q == RUN;
  // the wrong-path instruction is squashed in the same cycle a redirect arrives
  assign out_valid = run && !bad && !bus.redirect_valid_i;
  assign accept    = out_valid && bus.out_ready_i;
  assign stall     = out_valid && !bus.out_ready_i;
  always_comb begin
    state_d = state_q == IDLE ? (bus.start_i ? RUN : IDLE) :
              !run            ? state_q :
              bad             ? FAULT :
              (accept && bus.fetch_instr_i[5:0] == HALT_OPCODE) ? HALTED : RUN;
    pc_next = state_q == IDLE               ? RESET_PC :
              (run && !bad && bus.redirect_valid_i) ? bus.redirect_pc_i :
              accept                        ? bus.fetch_pc_i + 32'd4 : bus.fetch_pc_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      halted_q      <= state_d == HALTED;
      fault_q       <= state_d == FAULT;
      fetch_count_q <= fetch_count_q + 32'(accept && !(&fetch_count_q));
      stall_count_q <= stall_count_q + 32'(stall && !(&stall_count_q));
    end
  end
  assign bus.pc_next_o     = pc_next;
  assign bus.out_valid_o   = out_valid;
  assign bus.out_instr_o   = bus.fetch_instr_i;
  assign bus.out_pc_o      = bus.fetch_pc_i;
  assign bus.halted_o      = halted_q;
  assign bus.fault_o       = fault_q;
  assign bus.fetch_count_o = fetch_count_q;
  assign bus.stall_count_o = stall_count_q;
endmodule
